// File: rtl/vedic_mac_accum.sv
// Sums TERMS unsigned 8-bit products and tracks their maximum. The result registers
// are valid one cycle after the last accepted product. prod_ready is held low while a result waits for res_ready.
module vedic_mac_accum #(
   parameter int TERMS = 4,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             clear,
   input  logic [7:0]       prod_in,
   input  logic             prod_valid,
   output logic             prod_ready,
   output logic [ACC_W-1:0] res_sum,
   output logic [7:0]       res_max,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] TERMS_C = 8'(TERMS);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       max_q, max_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             accept;

   assign prod_ready = ena && (state_q != DONE);
   assign accept     = ena && !clear && prod_valid && prod_ready;
   assign res_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign res_sum    = acc_q;
   assign res_max    = max_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      // clear wins over both product acceptance and the result handshake
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         max_d   = '0;
         cnt_d   = '0;
      end else if (ena) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_d   = ACC_W'(prod_in);
                  max_d   = prod_in;
                  cnt_d   = 8'd1;
                  state_d = (TERMS_C == 8'd1) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_d   = acc_q + ACC_W'(prod_in);
                  max_d   = (prod_in > max_q) ? prod_in : max_q;
                  cnt_d   = cnt_q + 8'd1;
                  if (cnt_q + 8'd1 == TERMS_C) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  max_d   = '0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               max_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Bench for vedic_mac_accum: three instances (TERMS=4, 255, 1) share one stimulus stream
// and are checked every cycle against a batch-list model, plus literal checks of the named scenarios.
module tb_vedic_mac_accum;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       clear = 1'b0;
   logic [7:0] prod_in = 8'd0;
   logic       prod_valid = 1'b0;
   logic       res_ready = 1'b0;

   logic [2:0]       pr, rv, by;
   logic [2:0][15:0] rs;
   logic [2:0][7:0]  rm;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vedic_mac_accum #(.TERMS(4), .ACC_W(16)) u4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(pr[0]), .res_sum(rs[0]), .res_max(rm[0]),
      .res_valid(rv[0]), .res_ready(res_ready), .busy(by[0]));

   vedic_mac_accum #(.TERMS(255), .ACC_W(16)) u255 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(pr[1]), .res_sum(rs[1]), .res_max(rm[1]),
      .res_valid(rv[1]), .res_ready(res_ready), .busy(by[1]));

   vedic_mac_accum #(.TERMS(1), .ACC_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(pr[2]), .res_sum(rs[2]), .res_max(rm[2]),
      .res_valid(rv[2]), .res_ready(res_ready), .busy(by[2]));

   // Model: the list of products accepted into the current batch, and whether it is complete.
   int m_terms [3] = '{4, 255, 1};
   int m_prod  [3][256];
   int m_n     [3];
   bit m_done  [3];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n || clear) begin
            m_n[i] = 0; m_done[i] = 1'b0;
         end else if (ena) begin
            if (m_done[i]) begin
               if (res_ready) begin
                  m_n[i] = 0; m_done[i] = 1'b0;
               end
            end else if (prod_valid) begin
               m_prod[i][m_n[i]] = int'(prod_in);
               m_n[i]++;
               if (m_n[i] == m_terms[i]) m_done[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int s, mx;
         s = 0; mx = 0;
         for (int k = 0; k < m_n[i]; k++) begin
            s += m_prod[i][k];
            if (m_prod[i][k] > mx) mx = m_prod[i][k];
         end
         chk($sformatf("res_sum[%0d]", i), int'(rs[i]), s);
         chk($sformatf("res_max[%0d]", i), int'(rm[i]), mx);
         chk($sformatf("res_valid[%0d]", i), int'(rv[i]), int'(m_done[i]));
         chk($sformatf("busy[%0d]", i), int'(by[i]), int'(m_n[i] != 0));
         chk($sformatf("prod_ready[%0d]", i), int'(pr[i]), int'(ena && !m_done[i]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [7:0] p);
      prod_valid = v; prod_in = p;
      cyc();
   endtask

   task automatic do_clear();
      clear = 1'b1; prod_valid = 1'b0;
      cyc();
      clear = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq [4];
      seq = '{8'd6, 8'd20, 8'd225, 8'd0};
      #1;
      chk("reset_sum", int'(rs[0]), 0);
      chk("reset_valid", int'(rv[0]), 0);
      chk("reset_ready", int'(pr[0]), 1);
      cyc(); cyc();
      rst_n = 1'b1;

      // back-to-back batch
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) put(1'b1, seq[k]);
      prod_valid = 1'b0;
      chk("b2b_valid", int'(rv[0]), 1);
      chk("b2b_sum", int'(rs[0]), 251);
      chk("b2b_max", int'(rm[0]), 225);
      chk("b2b_ready_done", int'(pr[0]), 0);
      cyc();
      chk("b2b_valid_1cyc", int'(rv[0]), 0);
      chk("b2b_idle", int'(by[0]), 0);

      // gaps and backpressure
      res_ready = 1'b0;
      do_clear();
      for (int k = 0; k < 4; k++) begin
         put(1'b1, seq[k]); put(1'b0, 8'd0); put(1'b0, 8'd0);
      end
      for (int k = 0; k < 5; k++) begin
         prod_valid = 1'b1; prod_in = 8'd99;
         chk("bp_valid", int'(rv[0]), 1);
         chk("bp_sum", int'(rs[0]), 251);
         chk("bp_max", int'(rm[0]), 225);
         chk("bp_ready", int'(pr[0]), 0);
         cyc();
      end
      res_ready = 1'b1; prod_valid = 1'b0;
      cyc();
      chk("bp_released", int'(rv[0]), 0);
      put(1'b1, 8'd7);
      prod_valid = 1'b0;
      chk("bp_next_accepted", int'(rs[0]), 7);

      // clear mid-batch beats a simultaneous product
      do_clear();
      put(1'b1, 8'd6); put(1'b1, 8'd20);
      clear = 1'b1; prod_valid = 1'b1; prod_in = 8'd225;
      cyc();
      clear = 1'b0;
      chk("clr_sum", int'(rs[0]), 0);
      chk("clr_busy", int'(by[0]), 0);
      res_ready = 1'b0;
      for (int k = 0; k < 4; k++) put(1'b1, 8'd1);
      prod_valid = 1'b0;
      chk("clr_next_sum", int'(rs[0]), 4);
      chk("clr_next_max", int'(rm[0]), 1);
      res_ready = 1'b1;
      cyc();

      // asynchronous reset mid-batch
      do_clear();
      put(1'b1, 8'd6); put(1'b1, 8'd20);
      prod_valid = 1'b0;
      chk("rst_partial", int'(rs[0]), 26);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_sum", int'(rs[0]), 0);
      chk("rst_async_busy", int'(by[0]), 0);
      chk("rst_async_valid", int'(rv[0]), 0);
      cyc();
      rst_n = 1'b1;
      res_ready = 1'b0;
      put(1'b1, 8'd10); put(1'b1, 8'd20); put(1'b1, 8'd30); put(1'b1, 8'd40);
      prod_valid = 1'b0;
      chk("rst_after_sum", int'(rs[0]), 100);
      chk("rst_after_max", int'(rm[0]), 40);
      res_ready = 1'b1;
      cyc();

      // ena freeze
      res_ready = 1'b0;
      do_clear();
      put(1'b1, 8'd6);
      ena = 1'b0; prod_valid = 1'b1; prod_in = 8'd200;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("frz_sum", int'(rs[0]), 6);
         chk("frz_ready", int'(pr[0]), 0);
      end
      ena = 1'b1;
      put(1'b1, 8'd20); put(1'b1, 8'd225); put(1'b1, 8'd0);
      prod_valid = 1'b0;
      chk("frz_final", int'(rs[0]), 251);

      // upper bound: 255 products of 225
      do_clear();
      for (int k = 0; k < 255; k++) put(1'b1, 8'd225);
      prod_valid = 1'b0;
      chk("max_valid", int'(rv[1]), 1);
      chk("max_sum", int'(rs[1]), 57375);
      chk("max_max", int'(rm[1]), 225);
      res_ready = 1'b1;
      cyc();

      // TERMS=1
      res_ready = 1'b0;
      do_clear();
      put(1'b1, 8'd15);
      prod_valid = 1'b0;
      chk("t1_valid", int'(rv[2]), 1);
      chk("t1_sum", int'(rs[2]), 15);
      chk("t1_max", int'(rm[2]), 15);
      res_ready = 1'b1;
      cyc();
      chk("t1_consumed", int'(rv[2]), 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         ena        = ($urandom_range(0, 9) != 0);
         clear      = ($urandom_range(0, 39) == 0);
         prod_valid = ($urandom_range(0, 9) < 6);
         prod_in    = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
         res_ready  = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         cyc();
         rst_n = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
